// File: rtl/ed25519_sign_master.sv
// rtl/ed25519_sign_master.sv - bus master that sequences one Ed25519 signing job on a register-mapped engine
module ed25519_sign_master #(
  parameter int          ID_CHECK   = 1,
  parameter logic [31:0] POLL_LIMIT = 32'd1048576
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] sk,
  input  logic [255:0] pk,
  input  logic [255:0] msg,
  output logic         busy,
  output logic         done,
  output logic         fail,
  output logic [255:0] r_out,
  output logic [255:0] s_out,
  output logic         cs,
  output logic         we,
  output logic [7:0]   address,
  output logic [31:0]  write_data,
  input  logic [31:0]  read_data,
  input  logic         error
);

  localparam logic [31:0] NAME0 = 32'h65643235;

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK_ID, S_WRITE, S_WAIT_READY, S_START,
    S_WAIT_DONE, S_READ, S_DONE, S_FAULT
  } state_t;

  state_t        state;
  logic [255:0]  sk_q, pk_q, msg_q;
  logic [4:0]    idx;
  logic [4:0]    idx_nx;
  logic [31:0]  poll_cnt;
  logic          fault_hit;

  assign idx_nx = idx + 5'd1;

  // Write k: keys/message words land in 0x10, 0x20, 0x30 banks of eight
  function automatic logic [7:0] wr_addr(input logic [4:0] k);
    return {2'b00, k[4:3] + 2'd1, 1'b0, k[2:0]};
  endfunction

  function automatic logic [31:0] wr_word(input logic [4:0] k, input logic [255:0] a,
                                          input logic [255:0] b, input logic [255:0] c);
    logic [255:0] src;
    case (k[4:3])
      2'd0:    src = a;
      2'd1:    src = b;
      default: src = c;
    endcase
    return src[{k[2:0], 5'b0} +: 32];
  endfunction

  // Read j: R words at 0x40.., S words at 0x50..
  function automatic logic [7:0] rd_addr(input logic [4:0] j);
    return {3'b010, j[3], 1'b0, j[2:0]};
  endfunction

  // Abort condition for the access presented in the current cycle
  always_comb begin
    fault_hit = 1'b0;
    case (state)
      S_CHECK_ID:   fault_hit = error || (read_data != NAME0);
      S_WRITE,
      S_START,
      S_READ:       fault_hit = error;
      S_WAIT_READY: fault_hit = error || (!read_data[0] && poll_cnt == POLL_LIMIT - 32'd1);
      S_WAIT_DONE:  fault_hit = error || (!read_data[1] && poll_cnt == POLL_LIMIT - 32'd1);
      default:      fault_hit = 1'b0;
    endcase
  end

  // Job sequencer; bus outputs are registered and always describe the access of the current state
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cs         <= 1'b0;
      we         <= 1'b0;
      address    <= 8'h00;
      write_data <= 32'h0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      r_out      <= '0;
      s_out      <= '0;
      sk_q       <= '0;
      pk_q       <= '0;
      msg_q      <= '0;
      idx        <= 5'd0;
      poll_cnt   <= 32'd0;
    end else if (fault_hit) begin
      state      <= S_FAULT;
      cs         <= 1'b0;
      we         <= 1'b0;
      address    <= 8'h00;
      write_data <= 32'h0;
      busy       <= 1'b0;
      done       <= 1'b1;
      fail       <= 1'b1;
      r_out      <= '0;
      s_out      <= '0;
      idx        <= 5'd0;
      poll_cnt   <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sk_q  <= sk;
            pk_q  <= pk;
            msg_q <= msg;
            busy  <= 1'b1;
            fail  <= 1'b0;
            r_out <= '0;
            s_out <= '0;
            cs    <= 1'b1;
            idx   <= 5'd0;
            if (ID_CHECK != 0) begin
              state      <= S_CHECK_ID;
              we         <= 1'b0;
              address    <= 8'h00;
              write_data <= 32'h0;
            end else begin
              state      <= S_WRITE;
              we         <= 1'b1;
              address    <= 8'h10;
              write_data <= sk[31:0];
            end
          end
        end
        S_CHECK_ID: begin
          state      <= S_WRITE;
          we         <= 1'b1;
          address    <= 8'h10;
          write_data <= sk_q[31:0];
          idx        <= 5'd0;
        end
        S_WRITE: begin
          if (idx == 5'd23) begin
            state      <= S_WAIT_READY;
            we         <= 1'b0;
            address    <= 8'h09;
            write_data <= 32'h0;
            poll_cnt   <= 32'd0;
          end else begin
            idx        <= idx_nx;
            address    <= wr_addr(idx_nx);
            write_data <= wr_word(idx_nx, sk_q, pk_q, msg_q);
          end
        end
        S_WAIT_READY: begin
          if (read_data[0]) begin
            state      <= S_START;
            we         <= 1'b1;
            address    <= 8'h08;
            write_data <= 32'h00000001;
          end else begin
            poll_cnt <= poll_cnt + 32'd1;
          end
        end
        S_START: begin
          state      <= S_WAIT_DONE;
          we         <= 1'b0;
          address    <= 8'h09;
          write_data <= 32'h0;
          poll_cnt   <= 32'd0;
        end
        S_WAIT_DONE: begin
          if (read_data[1]) begin
            state   <= S_READ;
            address <= 8'h40;
            idx     <= 5'd0;
          end else begin
            poll_cnt <= poll_cnt + 32'd1;
          end
        end
        S_READ: begin
          if (!idx[3]) r_out[{idx[2:0], 5'b0} +: 32] <= read_data;
          else         s_out[{idx[2:0], 5'b0} +: 32] <= read_data;
          if (idx == 5'd15) begin
            state   <= S_DONE;
            cs      <= 1'b0;
            address <= 8'h00;
            busy    <= 1'b0;
            done    <= 1'b1;
            fail    <= 1'b0;
            idx     <= 5'd0;
          end else begin
            idx     <= idx_nx;
            address <= rd_addr(idx_nx);
          end
        end
        S_DONE:  state <= S_IDLE;
        S_FAULT: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
